otbn_alu_base_mc: RTL and testbench

// Parametrised, multi-cycle successor to the OTBN base ALU. Executes add/sub, logic, shifts and

---
 rtl/otbn_pkg.sv | 30 +++
 rtl/otbn_mul_iter.sv | 55 +++++
 rtl/otbn_alu_base_mc.sv | 154 +++++++++++++++
 tb/tb_otbn_alu_base_mc.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/otbn_pkg.sv
// Shared types for the multi-cycle OTBN base ALU: operation codes and FSM states.
package otbn_pkg;

  typedef enum logic [3:0] {
    OpAdd,
    OpSub,
    OpAnd,
    OpOr,
    OpXor,
    OpNot,
    OpSll,
    OpSrl,
    OpSra,
    OpRor,
    OpSlt,
    OpSltu,
    OpMull,
    OpMulh
  } alu_mc_op_e;

  typedef enum logic [0:0] {
    StIdle,
    StMul
  } alu_mc_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OpMull) || (op == OpMulh);
  endfunction

endpackage

// File: rtl/otbn_mul_iter.sv
// Iterative unsigned multiplier: consumes MulBitsPerCycle bits of operand B per cycle and
// accumulates shifted partial products into a 2*Width accumulator.
module otbn_mul_iter #(
  parameter int unsigned Width           = 32,
  parameter int unsigned MulBitsPerCycle = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               run_i,
  input  logic [Width-1:0]   operand_a_i,
  input  logic [Width-1:0]   operand_b_i,
  output logic               done_o,
  output logic [2*Width-1:0] product_o
);

  localparam int unsigned NumMulIter = Width / MulBitsPerCycle;
  localparam int unsigned CntW       = (NumMulIter > 1) ? $clog2(NumMulIter) : 1;

  logic [2*Width-1:0] a_sh_q;
  logic [Width-1:0]   b_sh_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*Width-1:0] acc_q, acc_d;
  logic [2*Width-1:0] chunk_ext, partial;

  // A is pre-shifted each iteration so the partial product needs no variable shift.
  always_comb begin
    chunk_ext = {{(2*Width-MulBitsPerCycle){1'b0}}, b_sh_q[MulBitsPerCycle-1:0]};
    partial   = a_sh_q * chunk_ext;
    acc_d     = acc_q + partial;
  end

  assign done_o    = run_i && (cnt_q == CntW'(NumMulIter - 1));
  assign product_o = acc_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (start_i) begin
      a_sh_q <= {{Width{1'b0}}, operand_a_i};
      b_sh_q <= operand_b_i;
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (run_i) begin
      a_sh_q <= a_sh_q << MulBitsPerCycle;
      b_sh_q <= b_sh_q >> MulBitsPerCycle;
      cnt_q  <= cnt_q + CntW'(1);
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/otbn_alu_base_mc.sv
// Multi-cycle OTBN base ALU: single-cycle arithmetic/logic/shift ops plus an iterative
// multiplier, with valid/ready handshakes on request and result sides.
module otbn_alu_base_mc
  import otbn_pkg::*;
#(
  parameter int unsigned Width           = 32,
  parameter int unsigned MulBitsPerCycle = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       op_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             busy_o
);

  localparam int unsigned ShAmtW     = $clog2(Width);
  localparam int unsigned NumMulIter = Width / MulBitsPerCycle;

  alu_mc_state_e    state_q;
  logic             out_valid_q, carry_q, zero_q, mulh_q;
  logic [Width-1:0] result_q;

  logic accept, op_mul, mul_start, mul_done;
  logic [2*Width-1:0] mul_product;
  logic [Width-1:0]   mul_res;

  assign in_ready_o = (state_q == StIdle) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign op_mul     = is_mul_op(op_i);
  assign mul_start  = accept && op_mul;

  // Single-cycle datapath.
  logic             sub_like, slt_bit, known;
  logic [Width-1:0] b_eff, alu_res;
  logic [Width:0]   sum;
  logic [ShAmtW-1:0] shamt;
  logic [2*Width-1:0] rot;
  logic             alu_carry, alu_zero;

  always_comb begin
    sub_like  = (op_i == OpSub) || (op_i == OpSlt) || (op_i == OpSltu);
    b_eff     = sub_like ? ~operand_b_i : operand_b_i;
    sum       = {1'b0, operand_a_i} + {1'b0, b_eff} + {{Width{1'b0}}, sub_like};
    shamt     = operand_b_i[ShAmtW-1:0];
    rot       = {operand_a_i, operand_a_i} >> shamt;
    // Differing signs decide SLT directly; otherwise a-b cannot overflow.
    slt_bit   = (operand_a_i[Width-1] ^ operand_b_i[Width-1]) ? operand_a_i[Width-1]
                                                               : sum[Width-1];
    alu_res   = '0;
    alu_carry = 1'b0;
    known     = 1'b1;
    case (alu_mc_op_e'(op_i))
      OpAdd, OpSub: begin
        alu_res   = sum[Width-1:0];
        alu_carry = sum[Width];
      end
      OpAnd:  alu_res = operand_a_i & operand_b_i;
      OpOr:   alu_res = operand_a_i | operand_b_i;
      OpXor:  alu_res = operand_a_i ^ operand_b_i;
      OpNot:  alu_res = ~operand_a_i;
      OpSll:  alu_res = operand_a_i << shamt;
      OpSrl:  alu_res = operand_a_i >> shamt;
      OpSra:  alu_res = $unsigned($signed(operand_a_i) >>> shamt);
      OpRor:  alu_res = rot[Width-1:0];
      OpSlt: begin
        alu_res   = {{(Width-1){1'b0}}, slt_bit};
        alu_carry = sum[Width];
      end
      OpSltu: begin
        alu_res   = {{(Width-1){1'b0}}, ~sum[Width]};
        alu_carry = sum[Width];
      end
      default: known = 1'b0;
    endcase
    alu_zero = known && (alu_res == '0);
  end

  otbn_mul_iter #(
    .Width           (Width),
    .MulBitsPerCycle (MulBitsPerCycle)
  ) u_mul_iter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (mul_start),
    .run_i       (state_q == StMul),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .done_o      (mul_done),
    .product_o   (mul_product)
  );

  assign mul_res = mulh_q ? mul_product[2*Width-1:Width] : mul_product[Width-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      mulh_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (mul_start) begin
            state_q <= StMul;
            mulh_q  <= (op_i == OpMulh);
          end
        end
        StMul:   if (mul_done) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (accept && !op_mul) begin
        out_valid_q <= 1'b1;
        result_q    <= alu_res;
        carry_q     <= alu_carry;
        zero_q      <= alu_zero;
      end else if (mul_done) begin
        out_valid_q <= 1'b1;
        result_q    <= mul_res;
        carry_q     <= 1'b0;
        zero_q      <= (mul_res == '0);
      end else if (out_valid_q && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign carry_o     = carry_q;
  assign zero_o      = zero_q;
  assign busy_o      = (state_q == StMul);

  a_no_accept_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    busy_o |-> (!in_ready_o && !out_valid_o));

  a_stable_bp: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i) |=>
      (out_valid_o && $stable(result_o) && $stable(carry_o) && $stable(zero_o)));

  a_mul_latency: assert property (@(posedge clk_i) disable iff (rst_i)
    mul_start |-> ##(NumMulIter + 1) out_valid_o);

endmodule

// File: tb/tb_otbn_alu_base_mc.sv
// Directed self-checking bench for otbn_alu_base_mc at Width=32, MulBitsPerCycle=4.
module tb_otbn_alu_base_mc;
  import otbn_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'h0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        carry, zero, busy;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        z;
  } vec_t;

  otbn_alu_base_mc #(
    .Width           (32),
    .MulBitsPerCycle (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .operand_a_i (a),
    .operand_b_i (b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .carry_o     (carry),
    .zero_o      (zero),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // lat counts edges from the accept edge (inclusive) to the edge that raised out_valid.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({out_valid, in_ready, busy, carry, zero, result} !== {5'b01000, 32'h0})
      $display("FAIL reset: got v=%b r=%b busy=%b c=%b z=%b res=%h want 0 1 0 0 0 0",
               out_valid, in_ready, busy, carry, zero, result);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_add;
    int lat;
    issue(OpAdd, 32'hFFFF_FFFF, 32'h1);
    wait_valid(lat);
    n_total++;
    if (lat != 1) $display("FAIL add_latency: got %0d want 1", lat);
    else n_pass++;
    n_total++;
    if ({out_valid, result, carry, zero} !== {1'b1, 32'h0, 1'b1, 1'b1})
      $display("FAIL add_wrap: got v=%b res=%h c=%b z=%b want 1 0 1 1",
               out_valid, result, carry, zero);
    else n_pass++;
  endtask

  task automatic test_alu_ops;
    vec_t v[14];
    int lat;
    v = '{
      '{OpSub,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0},
      '{OpSub,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1},
      '{OpAdd,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0},
      '{OpSlt,  32'hFFFF_FFFB, 32'h0000_0003, 32'h0000_0001, 1'b1, 1'b0},
      '{OpSltu, 32'hFFFF_FFFB, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1},
      '{OpSlt,  32'h0000_0003, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0, 1'b1},
      '{OpSra,  32'h8000_0000, 32'h0000_003F, 32'hFFFF_FFFF, 1'b0, 1'b0},
      '{OpRor,  32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0},
      '{OpRor,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0},
      '{OpSll,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1'b0},
      '{OpSrl,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0},
      '{OpAnd,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0},
      '{OpNot,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0},
      '{4'hE,   32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0}
    };
    for (int i = 0; i < 14; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      wait_valid(lat);
      n_total++;
      if ({lat == 1, result, carry, zero} !== {1'b1, v[i].res, v[i].c, v[i].z})
        $display("FAIL alu_vec%0d: got lat=%0d res=%h c=%b z=%b want lat=1 res=%h c=%b z=%b",
                 i, lat, result, carry, zero, v[i].res, v[i].c, v[i].z);
      else n_pass++;
    end
  endtask

  task automatic test_mul;
    vec_t v[5];
    int lat;
    logic bad;
    v = '{
      '{OpMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0},
      '{OpMull, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0},
      '{OpMull, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 1'b0, 1'b0},
      '{OpMulh, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0, 1'b0},
      '{OpMull, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b1}
    };
    for (int i = 0; i < 5; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      lat = 1;
      bad = 1'b0;
      // A competing request held during the multiply must be ignored.
      if (i == 0) begin
        in_valid = 1'b1;
        op = OpAdd;
        a = 32'h1;
        b = 32'h1;
      end
      while (!out_valid && lat < 40) begin
        if (!busy || in_ready) bad = 1'b1;
        @(posedge clk);
        #1;
        lat++;
      end
      in_valid = 1'b0;
      n_total++;
      if ({lat == 9, bad, result, carry, zero, busy} !== {2'b10, v[i].res, 1'b0, v[i].z, 1'b0})
        $display("FAIL mul_vec%0d: got lat=%0d busy_gap=%b res=%h c=%b z=%b busy=%b want lat=9 0 %h 0 %b 0",
                 i, lat, bad, result, carry, zero, busy, v[i].res, v[i].z);
      else n_pass++;
    end
    @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL mul_no_extra: got v=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] xa[4], xb[4], xr[4];
    xa = '{32'hF0F0_F0F0, 32'h1234_5678, 32'hA5A5_A5A5, 32'h0000_0001};
    xb = '{32'h0F0F_0F0F, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0003};
    xr = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h5A5A_5A5A, 32'h0000_0002};
    out_ready = 1'b0;
    issue(OpAdd, 32'h2, 32'h3);
    wait_valid(lat);
    n_total++;
    if ({lat == 1, out_valid, result} !== {2'b11, 32'h5})
      $display("FAIL bp_load: got lat=%0d v=%b res=%h want 1 1 5", lat, out_valid, result);
    else n_pass++;
    in_valid = 1'b1;
    op = OpXor;
    a = xa[0];
    b = xb[0];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_total++;
      if ({out_valid, in_ready, result, carry, zero} !== {2'b10, 32'h5, 2'b00})
        $display("FAIL bp_hold%0d: got v=%b r=%b res=%h c=%b z=%b want 1 0 5 0 0",
                 k, out_valid, in_ready, result, carry, zero);
      else n_pass++;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      op = OpXor;
      a = xa[k];
      b = xb[k];
      @(posedge clk);
      #1;
      n_total++;
      if ({out_valid, result, zero} !== {1'b1, xr[k], xr[k] == 32'h0})
        $display("FAIL b2b_xor%0d: got v=%b res=%h z=%b want 1 %h %b",
                 k, out_valid, result, zero, xr[k], xr[k] == 32'h0);
      else n_pass++;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL b2b_drain: got v=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mul;
    int lat;
    logic seen;
    issue(OpMull, 32'h3, 32'h4);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_total++;
    if ({out_valid, busy, in_ready} !== 3'b001)
      $display("FAIL mul_abort: got v=%b busy=%b r=%b want 0 0 1", out_valid, busy, in_ready);
    else n_pass++;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL mul_abort_quiet: got activity=%b want 0", seen);
    else n_pass++;
    issue(OpAdd, 32'h2, 32'h2);
    wait_valid(lat);
    n_total++;
    if ({lat == 1, result, zero} !== {1'b1, 32'h4, 1'b0})
      $display("FAIL post_abort_add: got lat=%0d res=%h z=%b want 1 4 0", lat, result, zero);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_mul();
    test_back_to_back();
    test_reset_mul();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
